// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front end: opcode constants, the NOP word,
// and the fetch-stage state and next-PC select encodings.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH,
    S_VALID,
    S_DROP
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIR,
    PC_LATCHED
  } pc_sel_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next fetch-address mux: hold / sequential +4 / fresh redirect / latched target.
// Purely combinational; redirect targets are word-aligned here and misalignment flagged.
module fetch_pc_sel
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  fetch_state_t    state,
  input  logic            imem_ack,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] drop_target,
  output logic [XLEN-1:0] next_fetch_pc,
  output logic [XLEN-1:0] next_target,
  output logic            misalign
);

  logic [XLEN-1:0] redir_tgt;
  pc_sel_t         sel;

  always_comb begin
    redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // A redirect newer than the latched one always wins.
    next_target = redirect_valid ? redir_tgt : drop_target;

    sel = PC_HOLD;
    case (state)
      S_FETCH: if (redirect_valid && imem_ack) sel = PC_REDIR;
      S_DROP:  if (imem_ack) sel = redirect_valid ? PC_REDIR : PC_LATCHED;
      S_VALID: begin
        if (redirect_valid)   sel = PC_REDIR;
        else if (instr_ready) sel = PC_INC;
      end
      default: sel = PC_HOLD;
    endcase

    case (sel)
      PC_INC:     next_fetch_pc = pc + XLEN'(4);
      PC_REDIR:   next_fetch_pc = redir_tgt;
      PC_LATCHED: next_fetch_pc = drop_target;
      default:    next_fetch_pc = fetch_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, imem req/ack, valid/ready instruction output; one instr per 2 cycles at best.
// Stale fetches after a redirect are drained in S_DROP; output holds while instr_ready is low.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err
);

  fetch_state_t    state;
  logic            req_q;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] drop_target;
  logic [XLEN-1:0] next_fetch_pc;
  logic [XLEN-1:0] next_target;
  logic            misalign;

  fetch_pc_sel #(.XLEN(XLEN)) u_pc_sel (
    .state          (state),
    .imem_ack       (imem_ack),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc),
    .pc             (pc),
    .drop_target    (drop_target),
    .next_fetch_pc  (next_fetch_pc),
    .next_target    (next_target),
    .misalign       (misalign)
  );

  // Reset masks the request immediately so a pending fetch is abandoned in the same cycle.
  assign imem_req  = req_q && !reset;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      req_q        <= 1'b1;
      fetch_pc     <= RESET_PC;
      drop_target  <= RESET_PC;
      instr        <= NOP_INSTR;
      opcode       <= NOP_INSTR[6:0];
      pc           <= RESET_PC;
      pc_plus4     <= RESET_PC + XLEN'(4);
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      fetch_pc    <= next_fetch_pc;
      drop_target <= next_target;
      if (misalign) misalign_err <= 1'b1;

      case (state)
        S_FETCH: begin
          if (redirect_valid) begin
            if (!imem_ack) state <= S_DROP;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            opcode      <= imem_rdata[6:0];
            pc          <= fetch_pc;
            pc_plus4    <= fetch_pc + XLEN'(4);
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= S_VALID;
          end
        end
        S_VALID: begin
          if (redirect_valid || instr_ready) begin
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_ack) state <= S_FETCH;
        end
        default: begin
          state       <= S_FETCH;
          req_q       <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic, checked
// against a program-order model of which PC the next presented instruction must carry.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign_err;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .opcode         (opcode),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: PC the next presented instruction must carry, sticky misalign.
  logic [31:0] exp_pc = 32'h100;
  logic        exp_mis = 1'b0;
  logic        redir_prev = 1'b0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;

  logic        obs_req, obs_valid, obs_mis;
  logic [31:0] obs_addr, obs_pc, obs_pp4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] opc;
    case (a[4:2])
      3'd0: opc = OPC_OP;
      3'd1: opc = OPC_LOAD;
      3'd2: opc = OPC_OP_IMM;
      3'd3: opc = OPC_STORE;
      3'd4: opc = OPC_BRANCH;
      3'd5: opc = OPC_JAL;
      3'd6: opc = OPC_LUI;
      default: opc = OPC_AUIPC;
    endcase
    return {a[26:2] ^ 25'h0A5_A5A5, opc};
  endfunction

  // One cycle: sample and check at negedge, then drive inputs for the next posedge.
  task automatic step(input bit ack_en, input bit rdy, input bit redir, input logic [31:0] tgt);
    logic [31:0] w;
    @(negedge clk);
    obs_req = imem_req;  obs_addr = imem_addr; obs_valid = instr_valid;
    obs_pc  = pc;        obs_pp4 = pc_plus4;   obs_mis = misalign_err;
    if (instr_valid) begin
      w = mem_word(exp_pc);
      check("pc", pc, exp_pc);
      check("instr", instr, w);
      check("opcode", 32'(opcode), 32'(w[6:0]));
      check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    end
    if (redir_prev) check("valid_after_redirect", 32'(instr_valid), 32'd0);
    check("misalign_err", 32'(misalign_err), 32'(exp_mis));
    if (prev_pending) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_stable", imem_addr, prev_addr);
    end
    if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);

    imem_ack       = ack_en && imem_req;
    imem_rdata     = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;

    prev_pending = imem_req && !imem_ack;
    prev_addr    = imem_addr;
    redir_prev   = redir;
    if (redir) begin
      exp_pc = {tgt[31:2], 2'b00};
      if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
    end else if (instr_valid && rdy) begin
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    #1 check("req_in_reset", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("req_in_reset2", 32'(imem_req), 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_opcode", 32'(opcode), 32'h13);
    check("rst_pc", pc, 32'h100);
    check("rst_pc_plus4", pc_plus4, 32'h104);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    reset = 1'b0;
    exp_pc = 32'h100; exp_mis = 1'b0; redir_prev = 1'b0; prev_pending = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      n++;
    end while (!obs_valid && n < max);
    check(tag, 32'(obs_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] tgt;
    do_reset();

    // Zero-wait memory, always ready: request every other cycle.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("zw_req", 32'(obs_req), 32'((k % 2) == 0));
      check("zw_valid", 32'(obs_valid), 32'((k % 2) == 1));
      if (k % 2 == 0) check("zw_addr", obs_addr, 32'h100 + 32'(2 * k));
    end

    // Backpressure: output held, no new request.
    wait_valid(20, "stall_wait");
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check("stall_req", 32'(obs_req), 32'd0);
      check("stall_valid", 32'(obs_valid), 32'd1);
    end
    step(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect while the ack is delayed: stale word dropped.
    step(1'b0, 1'b0, 1'b1, 32'h200);
    check("drop_req", 32'(obs_req), 32'd1);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check("drop_valid", 32'(obs_valid), 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("drop_next_addr", obs_addr, 32'h200);
    wait_valid(20, "drop_wait");
    check("drop_pc", obs_pc, 32'h200);

    // Redirect and ready together: target wins over pc+4.
    step(1'b0, 1'b1, 1'b1, 32'h400);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("rr_valid", 32'(obs_valid), 32'd0);
    check("rr_addr", obs_addr, 32'h400);
    wait_valid(20, "rr_wait");
    check("rr_pc", obs_pc, 32'h400);

    // Misaligned target.
    step(1'b0, 1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("mis_addr", obs_addr, 32'h200);
    check("mis_flag", 32'(obs_mis), 32'd1);
    wait_valid(20, "mis_wait");

    // PC wrap, then reset while a request is pending.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_valid(20, "wrap_wait");
    check("wrap_pc", obs_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", obs_pp4, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("wrap_req", 32'(obs_req), 32'd1);
    check("wrap_addr", obs_addr, 32'h0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if ($urandom_range(0, 2) != 0) tgt[1:0] = 2'b00;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 7) == 0), tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
